// File: rtl/obwb_write.sv
// Object-processor writeback writer: merges updated data/height/remainder fields
// into captured object phrases and writes them back. Optional OBWB_SKIP_ZERO_EN.
module obwb_write #(
    parameter int ADDR_W     = 21,
    parameter int PH2_OFFSET = 2
) (
    input  logic              clk,
    input  logic              resetl,
    input  logic              obld_0,
    input  logic              obld_2,
    input  logic [63:0]       d,
    input  logic [ADDR_W-1:0] obj_addr,
    input  logic              scaled,
    input  logic              wbstart,
    input  logic              wbkdone,
    input  logic [20:0]       newdata,
    input  logic [9:0]        newheight,
    input  logic [7:0]        newrem,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              wbdone
);

    typedef enum logic [2:0] {IDLE, WAITK, WR0, WR2, DONE} state_t;

    typedef struct packed {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
    } wr_t;

    localparam logic [63:0] MASK0 = 64'hFFFF_F800_00FF_C000;
    localparam logic [63:0] MASK2 = 64'h0000_0000_00FF_0000;

    state_t            state, nstate;
    logic [63:0]       ph0, ph2;
    logic [ADDR_W-1:0] base;
    logic              scaled_q, skip_q;
    wr_t               wr_q, wr_nxt;
    logic              busy_nxt, wbdone_nxt;

    logic              cap0, cap2, ack, enter_wr0, enter_wr2, skip_now;
    logic [63:0]       ph0_eff;
    logic [ADDR_W-1:0] base_eff;

    // Capture only while idle; same-edge capture must be visible to a WR0 entry.
    assign cap0     = (state == IDLE) && obld_0;
    assign cap2     = (state == IDLE) && obld_2;
    assign ph0_eff  = cap0 ? d : ph0;
    assign base_eff = cap0 ? obj_addr : base;
    assign ack      = wr_q.req && wr_ack;

    assign enter_wr0 = (nstate == WR0) && (state != WR0);
    assign enter_wr2 = (nstate == WR2) && (state != WR2);

`ifdef OBWB_SKIP_ZERO_EN
    assign skip_now = (newheight == 10'd0);
`else
    assign skip_now = 1'b0;
`endif

    // State, capture and registered outputs
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state    <= IDLE;
            ph0      <= '0;
            ph2      <= '0;
            base     <= '0;
            scaled_q <= 1'b0;
            skip_q   <= 1'b0;
            wr_q     <= '0;
            busy     <= 1'b0;
            wbdone   <= 1'b0;
        end else begin
            state <= nstate;
            if (cap0) begin
                ph0  <= d;
                base <= obj_addr;
            end
            if (cap2)
                ph2 <= d;
            if (enter_wr0) begin
                scaled_q <= scaled;
                skip_q   <= skip_now;
            end
            wr_q   <= wr_nxt;
            busy   <= busy_nxt;
            wbdone <= wbdone_nxt;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (wbstart) nstate = wbkdone ? WR0 : WAITK;
            WAITK:   if (wbkdone) nstate = WR0;
            WR0:     if (ack) nstate = (scaled_q && !skip_q) ? WR2 : DONE;
            WR2:     if (ack) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Address/data are loaded on entry to a write state and held until ack
    always_comb begin
        wr_nxt     = wr_q;
        wr_nxt.req = (nstate == WR0) || (nstate == WR2);
        if (enter_wr0) begin
            wr_nxt.addr = base_eff;
            wr_nxt.data = (ph0_eff & ~MASK0) | {newdata, 43'd0}
                        | {40'd0, newheight, 14'd0};
        end else if (enter_wr2) begin
            wr_nxt.addr = base + ADDR_W'(PH2_OFFSET);
            wr_nxt.data = (ph2 & ~MASK2) | {40'd0, newrem, 16'd0};
        end
        busy_nxt   = (nstate != IDLE);
        wbdone_nxt = (nstate == DONE);
    end

    assign wr_req  = wr_q.req;
    assign wr_addr = wr_q.addr;
    assign wr_data = wr_q.data;

endmodule

// File: tb/tb_obwb_write.sv
// Directed bench for obwb_write; write/done activity is logged on the falling edge.
module tb_obwb_write;

    logic        clk = 1'b0;
    logic        resetl = 1'b0;
    logic        obld_0 = 1'b0, obld_2 = 1'b0;
    logic [63:0] d = '0;
    logic [20:0] obj_addr = '0;
    logic        scaled = 1'b0, wbstart = 1'b0, wbkdone = 1'b1;
    logic [20:0] newdata = '0;
    logic [9:0]  newheight = '0;
    logic [7:0]  newrem = '0;
    logic        wr_req;
    logic [20:0] wr_addr;
    logic [63:0] wr_data;
    logic        wr_ack = 1'b0;
    logic        busy, wbdone;

    int pass_cnt = 0;
    int total_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [20:0] addr_log [0:63];
    logic [63:0] data_log [0:63];

    obwb_write #(.ADDR_W(21), .PH2_OFFSET(2)) dut (
        .clk(clk), .resetl(resetl), .obld_0(obld_0), .obld_2(obld_2), .d(d),
        .obj_addr(obj_addr), .scaled(scaled), .wbstart(wbstart), .wbkdone(wbkdone),
        .newdata(newdata), .newheight(newheight), .newrem(newrem),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy), .wbdone(wbdone)
    );

    always #5 clk = ~clk;

    // Inputs change 2 time units after a rising edge, so falling-edge values are final
    always @(negedge clk) begin
        if (resetl) begin
            if (wr_req && wr_ack) begin
                if (wr_cnt < 64) begin
                    addr_log[wr_cnt] = wr_addr;
                    data_log[wr_cnt] = wr_data;
                end
                wr_cnt++;
            end
            if (wbdone) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({wr_req, busy, wbdone} !== 3'b000)
            $display("FAIL reset_ctl: got %b expected 000", {wr_req, busy, wbdone});
        else pass_cnt++;
        total_cnt++;
        if ({wr_addr, wr_data} !== 85'd0)
            $display("FAIL reset_bus: got %h/%h expected 0/0", wr_addr, wr_data);
        else pass_cnt++;
        step();
        resetl = 1'b1;
        step();
    endtask

    task automatic test_unscaled();
        int w0;
        obld_0 = 1'b1; d = 64'h0123_4567_89AB_CDEF; obj_addr = 21'h100;
        newdata = 21'h1FFFFF; newheight = 10'h3A5; scaled = 1'b0; wr_ack = 1'b1;
        step();
        obld_0 = 1'b0; wbstart = 1'b1; w0 = wr_cnt;
        step();
        wbstart = 1'b0;
        total_cnt++;
        if ({wr_req, busy, wr_addr} !== {2'b11, 21'h100})
            $display("FAIL t1_req: got req=%b busy=%b addr=%h expected 1 1 100", wr_req, busy, wr_addr);
        else pass_cnt++;
        total_cnt++;
        if (wr_data !== 64'hFFFF_FD67_89E9_4DEF)
            $display("FAIL t1_data: got %h expected FFFFFD6789E94DEF", wr_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({wbdone, wr_req} !== 2'b10)
            $display("FAIL t1_done: got wbdone=%b req=%b expected 1 0", wbdone, wr_req);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({wbdone, busy, 32'(wr_cnt - w0)} !== {2'b00, 32'd1})
            $display("FAIL t1_end: got wbdone=%b busy=%b writes=%0d expected 0 0 1", wbdone, busy, wr_cnt - w0);
        else pass_cnt++;
    endtask

    task automatic test_scaled();
        int w0;
        obld_2 = 1'b1; d = 64'h0; scaled = 1'b1; newrem = 8'hC3; wr_ack = 1'b1;
        step();
        obld_2 = 1'b0; wbstart = 1'b1; w0 = wr_cnt;
        step();
        wbstart = 1'b0;
        total_cnt++;
        if ({wr_req, wr_addr, wr_data} !== {1'b1, 21'h100, 64'hFFFF_FD67_89E9_4DEF})
            $display("FAIL t2_ph0: got req=%b addr=%h data=%h", wr_req, wr_addr, wr_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({wr_req, wr_addr, wr_data} !== {1'b1, 21'h102, 64'h0000_0000_00C3_0000})
            $display("FAIL t2_ph2: got req=%b addr=%h data=%h expected 1 102 0000000000C30000", wr_req, wr_addr, wr_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({wbdone, wr_req} !== 2'b10)
            $display("FAIL t2_done: got wbdone=%b req=%b expected 1 0", wbdone, wr_req);
        else pass_cnt++;
        total_cnt++;
        if ((wr_cnt - w0 != 2) || (addr_log[w0] !== 21'h100) || (addr_log[w0+1] !== 21'h102))
            $display("FAIL t2_log: got writes=%0d addrs=%h,%h expected 2 100,102", wr_cnt - w0, addr_log[w0], addr_log[w0+1]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_ack_delay();
        int w0, d0;
        obld_0 = 1'b1; d = 64'hFFFF_FFFF_FFFF_FFFF; obj_addr = 21'h0ABCD;
        newdata = 21'h0; newheight = 10'h0; scaled = 1'b0; wr_ack = 1'b0;
        step();
        obld_0 = 1'b0; wbstart = 1'b1; w0 = wr_cnt; d0 = done_cnt;
        step();
        wbstart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({wr_req, wr_addr, wr_data} !== {1'b1, 21'h0ABCD, 64'h0000_07FF_FF00_3FFF})
                $display("FAIL t3_hold%0d: got req=%b addr=%h data=%h", i, wr_req, wr_addr, wr_data);
            else pass_cnt++;
            if (i == 1) begin
                wbstart = 1'b1; obld_0 = 1'b1; d = 64'h0; obj_addr = 21'h1;
            end else if (i == 2) begin
                wbstart = 1'b0; obld_0 = 1'b0;
            end
            step();
        end
        wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        total_cnt++;
        if (wbdone !== 1'b1)
            $display("FAIL t3_done: got %b expected 1", wbdone);
        else pass_cnt++;
        step(); step(); step();
        total_cnt++;
        if ({busy, 32'(wr_cnt - w0), 32'(done_cnt - d0)} !== {1'b0, 32'd1, 32'd1})
            $display("FAIL t3_once: got busy=%b writes=%0d dones=%0d expected 0 1 1", busy, wr_cnt - w0, done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_waitk();
        newdata = 21'h0; newheight = 10'h0; scaled = 1'b0; wr_ack = 1'b1; wbkdone = 1'b0;
        wbstart = 1'b1;
        step();
        wbstart = 1'b0;
        total_cnt++;
        if ({busy, wr_req} !== 2'b10)
            $display("FAIL t4_waitk: got busy=%b req=%b expected 1 0", busy, wr_req);
        else pass_cnt++;
        step(); step();
        total_cnt++;
        if (wr_req !== 1'b0)
            $display("FAIL t4_noreq: got %b expected 0", wr_req);
        else pass_cnt++;
        wbkdone = 1'b1;
        step();
        total_cnt++;
        if ({wr_req, wr_addr, wr_data} !== {1'b1, 21'h0ABCD, 64'h0000_07FF_FF00_3FFF})
            $display("FAIL t4_req: got req=%b addr=%h data=%h expected 1 0abcd 000007FFFF003FFF", wr_req, wr_addr, wr_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (wbdone !== 1'b1)
            $display("FAIL t4_done: got %b expected 1", wbdone);
        else pass_cnt++;
        step();
    endtask

    task automatic test_same_edge();
        obld_0 = 1'b1; d = 64'h0; obj_addr = 21'h055; wbstart = 1'b1;
        newdata = 21'h1; newheight = 10'h1; scaled = 1'b0; wr_ack = 1'b0;
        step();
        obld_0 = 1'b0; wbstart = 1'b0;
        total_cnt++;
        if ({wr_req, wr_addr, wr_data} !== {1'b1, 21'h055, 64'h0000_0800_0000_4000})
            $display("FAIL same_edge: got req=%b addr=%h data=%h expected 1 055 0000080000004000", wr_req, wr_addr, wr_data);
        else pass_cnt++;
        wr_ack = 1'b1;
        step(); step();
        wr_ack = 1'b0;
    endtask

    task automatic test_wrap();
        obld_0 = 1'b1; obld_2 = 1'b1; d = 64'h1111_2222_3333_4444; obj_addr = 21'h1FFFFF;
        newdata = 21'h0; newheight = 10'h001; newrem = 8'h5A; scaled = 1'b1; wr_ack = 1'b1;
        step();
        obld_0 = 1'b0; obld_2 = 1'b0; wbstart = 1'b1;
        step();
        wbstart = 1'b0;
        total_cnt++;
        if ({wr_addr, wr_data} !== {21'h1FFFFF, 64'h0000_0222_3300_4444})
            $display("FAIL t5_ph0: got addr=%h data=%h expected 1fffff 0000022233004444", wr_addr, wr_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({wr_req, wr_addr, wr_data} !== {1'b1, 21'h000001, 64'h1111_2222_335A_4444})
            $display("FAIL t5_wrap: got req=%b addr=%h data=%h expected 1 000001 11112222335A4444", wr_req, wr_addr, wr_data);
        else pass_cnt++;
        step(); step();
    endtask

    task automatic test_reset_mid();
        int w0, d0;
        wr_ack = 1'b0; scaled = 1'b1; newheight = 10'h001; wbstart = 1'b1;
        w0 = wr_cnt; d0 = done_cnt;
        step();
        wbstart = 1'b0; wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        total_cnt++;
        if ({wr_req, wr_addr} !== {1'b1, 21'h000001})
            $display("FAIL t6_wr2: got req=%b addr=%h expected 1 000001", wr_req, wr_addr);
        else pass_cnt++;
        #1 resetl = 1'b0;
        #1;
        total_cnt++;
        if ({wr_req, busy, wbdone, wr_addr, wr_data} !== 88'd0)
            $display("FAIL t6_async: got req=%b busy=%b addr=%h data=%h expected all 0", wr_req, busy, wr_addr, wr_data);
        else pass_cnt++;
        step();
        resetl = 1'b1;
        step(); step(); step();
        total_cnt++;
        if ({busy, wr_req, 32'(wr_cnt - w0), 32'(done_cnt - d0)} !== {2'b00, 32'd1, 32'd0})
            $display("FAIL t6_after: got busy=%b req=%b writes=%0d dones=%0d expected 0 0 1 0", busy, wr_req, wr_cnt - w0, done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_skip_zero();
        int w0, d0, exp_w;
`ifdef OBWB_SKIP_ZERO_EN
        exp_w = 1;
`else
        exp_w = 2;
`endif
        obld_0 = 1'b1; obld_2 = 1'b1; d = 64'h0; obj_addr = 21'h200;
        newdata = 21'h5; newheight = 10'h0; newrem = 8'h07; scaled = 1'b1; wr_ack = 1'b1;
        step();
        obld_0 = 1'b0; obld_2 = 1'b0; wbstart = 1'b1; w0 = wr_cnt; d0 = done_cnt;
        step();
        wbstart = 1'b0;
        repeat (5) step();
        total_cnt++;
        if ((wr_cnt - w0 != exp_w) || (done_cnt - d0 != 1))
            $display("FAIL skip_zero: got writes=%0d dones=%0d expected %0d 1", wr_cnt - w0, done_cnt - d0, exp_w);
        else pass_cnt++;
        wr_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unscaled();
        test_scaled();
        test_ack_delay();
        test_waitk();
        test_same_edge();
        test_wrap();
        test_reset_mid();
        test_skip_zero();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
